// File: rtl/scanline_synth.sv
// ---------------------------------------------------------------------------
// scanline_synth -- multi-voice scanline-rate audio synthesiser.
//
// Each voice is either a square tone or the shared noise source. The voice
// output is gated by a decaying envelope. Tones and noise advance once per
// scanline (line_tick), and envelopes advance once per frame (frame_tick).
// The voices are summed into a level that is latched at the start of each
// scanline. A PWM stage then drives the 1-bit audio output high for
// `level` clocks of that line.
//
// Optional feature (macro SCANLINE_SYNTH_SWEEP_EN):
//   On each frame_tick, every voice that has sweep_en set and a nonzero
//   envelope lengthens its half-period by one, saturating at the maximum.
//   This gives a falling-pitch "kick". A period_we to the same voice in the
//   same cycle takes priority over the sweep. When the macro is not
//   defined, sweep_en is ignored.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   line_tick    one-cycle pulse at the start of each scanline
//   frame_tick   one-cycle pulse once per frame (may coincide with line_tick)
//   trig         per-voice retrigger pulses (sticky until the next frame_tick)
//   voice_noise  per-voice gate source: 1 = noise bit, 0 = tone phase
//   sweep_en     per-voice pitch sweep enable (sweep build only)
//   period_we    write strobe for a half-period register
//   period_sel   voice index for the write (out-of-range indices are ignored)
//   period_data  half-period value, in scanlines (half-period = value + 1)
//   audio_out    PWM audio bit
//   level_out    mix level latched for the current scanline
//   env_active   bit i set while the envelope of voice i is nonzero
// ---------------------------------------------------------------------------
module scanline_synth #(
  parameter int          NUM_VOICES = 3,
  parameter int          PERIOD_W   = 9,
  parameter int          ENV_W      = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         SEL_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int         LEVEL_W    = ENV_W + $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_tick,
  input  logic                  frame_tick,
  input  logic [NUM_VOICES-1:0] trig,
  input  logic [NUM_VOICES-1:0] voice_noise,
  input  logic [NUM_VOICES-1:0] sweep_en,
  input  logic                  period_we,
  input  logic [SEL_W-1:0]      period_sel,
  input  logic [PERIOD_W-1:0]   period_data,
  output logic                  audio_out,
  output logic [LEVEL_W-1:0]    level_out,
  output logic [NUM_VOICES-1:0] env_active
);

  localparam logic [ENV_W-1:0] ENV_MAX  = {ENV_W{1'b1}};
  localparam logic [15:0]      LFSR_TAP = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam int               PWM_W    = LEVEL_W + 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PERIOD_W-1:0]   period_q [NUM_VOICES];
  logic [PERIOD_W-1:0]   period_d [NUM_VOICES];
  logic [PERIOD_W-1:0]   cnt_q    [NUM_VOICES];
  logic [PERIOD_W-1:0]   cnt_d    [NUM_VOICES];
  logic [ENV_W-1:0]      env_q    [NUM_VOICES];
  logic [ENV_W-1:0]      env_d    [NUM_VOICES];
  logic [NUM_VOICES-1:0] phase_q, phase_d;
  logic [NUM_VOICES-1:0] pend_q, pend_d;
  logic [NUM_VOICES-1:0] env_active_q, env_active_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic [PWM_W-1:0]      pwm_q, pwm_d;
  logic                  audio_q, audio_d;

  // -------------------------------------------------------------------------
  // Mix: computed from the current (pre-update) state, so a line_tick that
  // coincides with tone, noise or envelope updates still latches the
  // values that were present during the tick cycle.
  // -------------------------------------------------------------------------
  logic [NUM_VOICES-1:0] gate;
  logic [LEVEL_W-1:0]    mix;

  assign gate = (voice_noise & {NUM_VOICES{lfsr_q[0]}}) | (~voice_noise & phase_q);

  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate[i]) mix = mix + LEVEL_W'(env_q[i]);
    end
  end

`ifndef SCANLINE_SYNTH_SWEEP_EN
  logic sweep_unused;
  assign sweep_unused = ^sweep_en;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first, so that no path leaves a
    // variable unassigned and no latch is inferred.
    period_d     = period_q;
    cnt_d        = cnt_q;
    env_d        = env_q;
    phase_d      = phase_q;
    pend_d       = pend_q;
    env_active_d = '0;
    lfsr_d       = lfsr_q;
    level_d      = level_q;

    // Scanline-rate updates: tone dividers, noise LFSR and mix latch.
    if (line_tick) begin
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAP : 16'h0000);
      level_d = mix;
      for (int i = 0; i < NUM_VOICES; i++) begin
        // ">=" rather than "==" means that a period rewritten below the
        // running count still toggles on the next line.
        if (cnt_q[i] >= period_q[i]) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
`ifdef SCANLINE_SYNTH_SWEEP_EN
      if (frame_tick && sweep_en[i] && (env_q[i] != '0) &&
          (period_q[i] != {PERIOD_W{1'b1}})) begin
        period_d[i] = period_q[i] + 1'b1;
      end
`endif
      // A host write takes priority over the sweep.
      if (period_we && (int'(period_sel) == i)) begin
        period_d[i] = period_data;
      end

      // A trigger in the same cycle as frame_tick is consumed at once.
      pend_d[i] = pend_q[i] | trig[i];
      if (frame_tick) begin
        if (pend_d[i]) begin
          env_d[i] = ENV_MAX;
        end else if (env_q[i] != '0) begin
          env_d[i] = env_q[i] - 1'b1;
        end
        pend_d[i] = 1'b0;
      end
      env_active_d[i] = (env_d[i] != '0);
    end
  end

  // The PWM counter restarts at every line and then saturates. This keeps
  // the output low on lines that are longer than the counter range.
  always_comb begin
    if (line_tick) begin
      pwm_d = '0;
    end else if (pwm_q != {PWM_W{1'b1}}) begin
      pwm_d = pwm_q + 1'b1;
    end else begin
      pwm_d = pwm_q;
    end
  end

  // The comparison uses the registered counter and level. The first high
  // cycle therefore lands two cycles after the line_tick cycle.
  assign audio_d = (pwm_q < {1'b0, level_q});

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the small per-voice arrays are reset explicitly, because the
      // tone dividers and envelopes must start silent and in a known phase.
      for (int i = 0; i < NUM_VOICES; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
        env_q[i]    <= '0;
      end
      phase_q      <= '0;
      pend_q       <= '0;
      env_active_q <= '0;
      lfsr_q       <= LFSR_SEED;
      level_q      <= '0;
      pwm_q        <= {PWM_W{1'b1}};
      audio_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
        env_q[i]    <= env_d[i];
      end
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      env_active_q <= env_active_d;
      lfsr_q       <= lfsr_d;
      level_q      <= level_d;
      pwm_q        <= pwm_d;
      audio_q      <= audio_d;
    end
  end

  assign audio_out  = audio_q;
  assign level_out  = level_q;
  assign env_active = env_active_q;

endmodule
